// File: rtl/audio_mix.sv
// audio_mix: PSG channel mixer with stereo panning, beeper/tape injection,
// master gain and per-side first-order sigma-delta DAC outputs.
// A pass runs IDLE -> ACCUM (NCH cycles) -> SCALE -> OUTPUT -> IDLE.
// Build option: define AUDIO_MIX_SATURATE_EN to clamp the mix at full scale
// instead of keeping only its low OUT_W bits.
module audio_mix #(
    parameter int NCH   = 3,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                  clk50m,
    input  logic                  reset,
    input  logic                  ce_sample,
    input  logic [NCH*IN_W-1:0]   psg_in,
    input  logic [1:0]            stereo_mode,
    input  logic [1:0]            gain,
    input  logic                  ear,
    input  logic                  mic,
    output logic [OUT_W-1:0]      pcm_l,
    output logic [OUT_W-1:0]      pcm_r,
    output logic                  pcm_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  aud_left,
    output logic                  aud_right
);
    localparam int IDX_W = $clog2(NCH);
    localparam int ACC_W = IN_W + $clog2(NCH) + 1;
    localparam int MIX_W = OUT_W + 4;
    localparam int SH    = OUT_W - 1 - ACC_W;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCALE, S_OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [NCH*IN_W-1:0]   psg_q, psg_d;
    logic [1:0]            mode_q, mode_d;
    logic [1:0]            gain_q, gain_d;
    logic                  ear_q, ear_d, mic_q, mic_d;
    logic [ACC_W-1:0]      acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [OUT_W-1:0]      pcm_l_q, pcm_l_d, pcm_r_q, pcm_r_d;
    logic [OUT_W:0]        sd_l_q, sd_l_d, sd_r_q, sd_r_d;

    logic [IN_W-1:0]       ch;
    logic [ACC_W-1:0]      ch_x1, ch_x2, add_l, add_r;
    logic [1:0]            wl, wr;
    logic [MIX_W-1:0]      inj, mix_l, mix_r;
    logic [OUT_W-1:0]      lim_l, lim_r;

    // Per-channel pan weights: a weight of 2 is a hard pan, 1 is centre.
    always_comb begin
        wl = 2'd1;
        wr = 2'd1;
        if (mode_q == 2'b01) begin
            if (idx_q == IDX_W'(0))      begin wl = 2'd2; wr = 2'd0; end
            else if (idx_q == IDX_W'(2)) begin wl = 2'd0; wr = 2'd2; end
        end else if (mode_q == 2'b10) begin
            if (idx_q == IDX_W'(0))      begin wl = 2'd2; wr = 2'd0; end
            else if (idx_q == IDX_W'(1)) begin wl = 2'd0; wr = 2'd2; end
        end
    end

    // Selected channel scaled by its weight, and the mix datapath for SCALE.
    always_comb begin
        ch    = psg_q[int'(idx_q)*IN_W +: IN_W];
        ch_x1 = ACC_W'(ch);
        ch_x2 = ch_x1 << 1;
        add_l = (wl == 2'd2) ? ch_x2 : (wl == 2'd1) ? ch_x1 : '0;
        add_r = (wr == 2'd2) ? ch_x2 : (wr == 2'd1) ? ch_x1 : '0;
        inj   = (ear_q ? (MIX_W'(1) << (OUT_W-3)) : '0)
              + (mic_q ? (MIX_W'(1) << (OUT_W-4)) : '0);
        mix_l = ((MIX_W'(acc_l_q) << SH) + inj) << gain_q;
        mix_r = ((MIX_W'(acc_r_q) << SH) + inj) << gain_q;
    end

`ifdef AUDIO_MIX_SATURATE_EN
    // Clamp anything above full scale.
    always_comb begin
        lim_l = (|mix_l[MIX_W-1:OUT_W]) ? '1 : mix_l[OUT_W-1:0];
        lim_r = (|mix_r[MIX_W-1:OUT_W]) ? '1 : mix_r[OUT_W-1:0];
    end
`else
    // Keep the low bits; overflow wraps.
    logic unused_mix_hi;
    always_comb begin
        lim_l         = mix_l[OUT_W-1:0];
        lim_r         = mix_r[OUT_W-1:0];
        unused_mix_hi = ^{mix_l[MIX_W-1:OUT_W], mix_r[MIX_W-1:OUT_W]};
    end
`endif

    // Next-state and datapath updates. The limited mix is loaded on leaving
    // SCALE so that it is already on pcm_l/pcm_r while OUTPUT flags it valid.
    always_comb begin
        state_d = state_q;
        psg_d   = psg_q;
        mode_d  = mode_q;
        gain_d  = gain_q;
        ear_d   = ear_q;
        mic_d   = mic_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        idx_d   = idx_q;
        pcm_l_d = pcm_l_q;
        pcm_r_d = pcm_r_q;
        unique case (state_q)
            S_IDLE: if (ce_sample) begin
                psg_d   = psg_in;
                mode_d  = stereo_mode;
                gain_d  = gain;
                ear_d   = ear;
                mic_d   = mic;
                acc_l_d = '0;
                acc_r_d = '0;
                idx_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_l_d = acc_l_q + add_l;
                acc_r_d = acc_r_q + add_r;
                if (idx_q == IDX_W'(NCH-1)) state_d = S_SCALE;
                else                        idx_d   = idx_q + IDX_W'(1);
            end
            S_SCALE: begin
                pcm_l_d = lim_l;
                pcm_r_d = lim_r;
                state_d = S_OUTPUT;
            end
            default: state_d = S_IDLE;
        endcase
        // Sigma-delta: carry out of the low OUT_W bits is the output bit.
        sd_l_d = {1'b0, sd_l_q[OUT_W-1:0]} + {1'b0, pcm_l_q};
        sd_r_d = {1'b0, sd_r_q[OUT_W-1:0]} + {1'b0, pcm_r_q};
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk50m) begin
        if (reset) begin
            state_q <= S_IDLE;
            psg_q   <= '0;
            mode_q  <= '0;
            gain_q  <= '0;
            ear_q   <= 1'b0;
            mic_q   <= 1'b0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            idx_q   <= '0;
            pcm_l_q <= '0;
            pcm_r_q <= '0;
            sd_l_q  <= '0;
            sd_r_q  <= '0;
        end else begin
            state_q <= state_d;
            psg_q   <= psg_d;
            mode_q  <= mode_d;
            gain_q  <= gain_d;
            ear_q   <= ear_d;
            mic_q   <= mic_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            idx_q   <= idx_d;
            pcm_l_q <= pcm_l_d;
            pcm_r_q <= pcm_r_d;
            sd_l_q  <= sd_l_d;
            sd_r_q  <= sd_r_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign pcm_valid = (state_q == S_OUTPUT);
    assign overrun   = ce_sample & busy & ~reset;
    assign pcm_l     = pcm_l_q;
    assign pcm_r     = pcm_r_q;
    assign aud_left  = sd_l_q[OUT_W];
    assign aud_right = sd_r_q[OUT_W];
endmodule

// File: tb/tb_audio_mix.sv
// tb_audio_mix: directed checks of audio_mix at NCH=3, IN_W=8, OUT_W=16.
module tb_audio_mix;
    logic        clk50m = 1'b0;
    logic        reset, ce_sample;
    logic [23:0] psg_in;
    logic [1:0]  stereo_mode, gain;
    logic        ear, mic;
    logic [15:0] pcm_l, pcm_r;
    logic        pcm_valid, busy, overrun, aud_left, aud_right;
    int          checks = 0;
    int          errors = 0;

    audio_mix #(.NCH(3), .IN_W(8), .OUT_W(16)) dut (
        .clk50m(clk50m), .reset(reset), .ce_sample(ce_sample), .psg_in(psg_in),
        .stereo_mode(stereo_mode), .gain(gain), .ear(ear), .mic(mic),
        .pcm_l(pcm_l), .pcm_r(pcm_r), .pcm_valid(pcm_valid), .busy(busy),
        .overrun(overrun), .aud_left(aud_left), .aud_right(aud_right)
    );

    always #5 clk50m = ~clk50m;

    task automatic tick();
        @(posedge clk50m);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full pass; inputs are scrambled right after the strobe.
    task automatic run_pass(input string tag, input logic [1:0] md, input logic [1:0] g,
                            input logic e, input logic m, input logic [23:0] psg,
                            input logic [15:0] el, input logic [15:0] er);
        stereo_mode = md; gain = g; ear = e; mic = m; psg_in = psg; ce_sample = 1'b1;
        #1;
        chk($sformatf("%s.ovr_c0", tag), overrun, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin
                ce_sample = 1'b0; psg_in = ~psg; stereo_mode = ~md; gain = ~g; ear = ~e; mic = ~m;
                #1;
            end
            chk($sformatf("%s.busy_c%0d", tag, c), busy, 1);
            if (c < 5) chk($sformatf("%s.valid_c%0d", tag, c), pcm_valid, 0);
            else begin
                chk($sformatf("%s.valid_c5", tag), pcm_valid, 1);
                chk($sformatf("%s.pcm_l", tag), pcm_l, el);
                chk($sformatf("%s.pcm_r", tag), pcm_r, er);
            end
        end
        tick();
        chk($sformatf("%s.valid_c6", tag), pcm_valid, 0);
        chk($sformatf("%s.busy_c6", tag), busy, 0);
        chk($sformatf("%s.hold_l", tag), pcm_l, el);
        chk($sformatf("%s.hold_r", tag), pcm_r, er);
    endtask

    initial begin
        logic [15:0] e35_l, e35_r;
`ifdef AUDIO_MIX_SATURATE_EN
        e35_l = 16'hFFFF; e35_r = 16'hFFFF;
`else
        e35_l = 16'hFE80; e35_r = 16'hFF80;
`endif
        reset = 1'b1; ce_sample = 1'b0; psg_in = '0; stereo_mode = '0;
        gain = '0; ear = 1'b0; mic = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.valid", pcm_valid, 0);
        chk("rst.ovr", overrun, 0);
        chk("rst.pcm_l", pcm_l, 0);
        chk("rst.pcm_r", pcm_r, 0);
        chk("rst.aud", {aud_left, aud_right}, 0);
        tick();

        run_pass("mono10",  2'b00, 2'd0, 0, 0, 24'h101010, 16'h0300, 16'h0300);
        run_pass("abc_ff",  2'b01, 2'd0, 0, 0, 24'h0000FF, 16'h1FE0, 16'h0000);
        run_pass("acb_ff",  2'b10, 2'd0, 0, 0, 24'h0000FF, 16'h1FE0, 16'h0000);
        run_pass("earmic",  2'b00, 2'd0, 1, 1, 24'h000000, 16'h3000, 16'h3000);
        run_pass("mono11",  2'b11, 2'd0, 0, 0, 24'h030201, 16'h0060, 16'h0060);
        run_pass("abc_pan", 2'b01, 2'd0, 0, 0, 24'h040201, 16'h0040, 16'h00A0);
        run_pass("acb_pan", 2'b10, 2'd0, 0, 0, 24'h040201, 16'h0060, 16'h0080);
        run_pass("gain1",   2'b00, 2'd1, 0, 0, 24'h101010, 16'h0600, 16'h0600);
        run_pass("limit",   2'b01, 2'd3, 1, 1, 24'h00FFFF, e35_l, e35_r);

        // Strobes at cycle 0, 2 (ACCUM) and 5 (OUTPUT) -> one pass only.
        stereo_mode = 2'b00; gain = 2'd0; ear = 0; mic = 0; psg_in = 24'h101010;
        ce_sample = 1'b1;
        tick(); ce_sample = 1'b0; #1;
        chk("ovr.c1", overrun, 0);
        tick(); psg_in = 24'hFFFFFF; ce_sample = 1'b1; #1;
        chk("ovr.c2", overrun, 1);
        tick(); ce_sample = 1'b0; #1;
        chk("ovr.c3", overrun, 0);
        tick();
        chk("ovr.valid_c4", pcm_valid, 0);
        tick(); ce_sample = 1'b1; #1;
        chk("ovr.valid_c5", pcm_valid, 1);
        chk("ovr.pcm_l", pcm_l, 16'h0300);
        chk("ovr.pcm_r", pcm_r, 16'h0300);
        chk("ovr.c5", overrun, 1);
        tick(); ce_sample = 1'b0; #1;
        chk("ovr.busy_c6", busy, 0);
        tick();
        chk("ovr.busy_c7", busy, 0);
        chk("ovr.valid_c7", pcm_valid, 0);

        // Sigma-delta from a clean reset: pcm 0 gives zeros, 0x8000 alternates.
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("sd.zero", {aud_left, aud_right}, 0);
        run_pass("sd8000", 2'b00, 2'd2, 1, 0, 24'h000000, 16'h8000, 16'h8000);
        chk("sd.c6", {aud_left, aud_right}, 2'b00);
        tick(); chk("sd.c7", {aud_left, aud_right}, 2'b11);
        tick(); chk("sd.c8", {aud_left, aud_right}, 2'b00);
        tick(); chk("sd.c9", {aud_left, aud_right}, 2'b11);
        tick(); chk("sd.c10", {aud_left, aud_right}, 2'b00);

        // Reset at cycle 3 of a pass aborts it.
        stereo_mode = 2'b01; gain = 2'd0; psg_in = 24'h0000FF; ce_sample = 1'b1;
        tick(); ce_sample = 1'b0;
        tick(); tick(); reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("rmid.busy", busy, 0);
        chk("rmid.valid", pcm_valid, 0);
        chk("rmid.pcm", {pcm_l, pcm_r}, 0);
        chk("rmid.aud", {aud_left, aud_right}, 0);
        chk("rmid.ovr", overrun, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("rmid.novalid%0d", i), pcm_valid, 0);
        end

        // Strobe coincident with reset is ignored.
        reset = 1'b1; ce_sample = 1'b1;
        tick(); reset = 1'b0; ce_sample = 1'b0; #1;
        chk("rce.busy", busy, 0);
        run_pass("recover", 2'b00, 2'd0, 0, 0, 24'h101010, 16'h0300, 16'h0300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_mix.md
AUDIO_MIX -- requirements
Module: audio_mix

Interface
REQ-001 SHALL have parameter NCH, default 3, meaning the number of PSG channels (legal range 3..8).
REQ-002 SHALL have parameter IN_W, default 8, meaning the unsigned width of each channel sample.
REQ-003 SHALL have parameter OUT_W, default 16, meaning the unsigned offset-binary PCM width.
REQ-004 SHALL have port clk50m, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ce_sample, input, 1 bit: one-cycle strobe that starts a mixing pass.
REQ-007 SHALL have port psg_in, input, NCH*IN_W bits: channel k occupies bits [k*IN_W +: IN_W].
REQ-008 SHALL have port stereo_mode, input, 2 bits: 00 = mono, 01 = ABC, 10 = ACB, 11 = mono.
REQ-009 SHALL have port gain, input, 2 bits: master left shift of 0..3.
REQ-010 SHALL have ports ear and mic, input, 1 bit each: beeper and tape-input levels.
REQ-011 SHALL have ports pcm_l and pcm_r, output, OUT_W bits each: mixed samples.
REQ-012 SHALL have port pcm_valid, output, 1 bit: one-cycle pulse when pcm_l/pcm_r update.
REQ-013 SHALL have port busy, output, 1 bit: high while the state is not IDLE.
REQ-014 SHALL have port overrun, output, 1 bit: one-cycle pulse when a ce_sample is dropped.
REQ-015 SHALL have ports aud_left and aud_right, output, 1 bit each: sigma-delta DAC bitstreams.

Function
REQ-016 SHALL implement a state machine IDLE -> ACCUM -> SCALE -> OUTPUT -> IDLE.
REQ-017 In IDLE, ce_sample=1 SHALL do all of the following in one action:
- snapshot psg_in, stereo_mode, gain, ear and mic;
- clear accL and accR;
- set idx=0;
- enter ACCUM.
REQ-018 ACCUM SHALL add one channel (idx) per cycle to accL/accR using these weights:
- mono: 1/1 for every channel;
- ABC: ch0 = L2/R0, ch1 = L1/R1, ch2 = L0/R2;
- ACB: ch0 = L2/R0, ch2 = L1/R1, ch1 = L0/R2;
- ch3..NCH-1: 1/1 in every mode.
REQ-019 ACCUM SHALL last exactly NCH cycles and then enter SCALE.
REQ-020 Accumulator width SHALL be ACC_W = IN_W + clog2(NCH) + 1, and the accumulators SHALL never wrap.
REQ-021 SCALE SHALL compute, per side, with OUT_W+4 bits of headroom: mix = ((acc << (OUT_W-1-ACC_W)) + (ear ? 2^(OUT_W-3) : 0) + (mic ? 2^(OUT_W-4) : 0)) << gain.
REQ-022 OUTPUT SHALL register the limited mix (REQ-031) into pcm_l/pcm_r, pulse pcm_valid, and return to IDLE.
REQ-023 Latency: a ce_sample accepted in cycle 0 SHALL produce pcm_valid in cycle NCH+2; the sustainable strobe period is NCH+3 cycles.
REQ-024 A ce_sample arriving while busy=1 (including in OUTPUT) SHALL be ignored, SHALL pulse overrun for one cycle, and SHALL NOT disturb the pass in progress.
REQ-025 Input changes after the snapshot SHALL NOT affect the pass in progress.
REQ-026 pcm_l/pcm_r SHALL hold their values between pcm_valid pulses.
REQ-027 Each side SHALL have a first-order sigma-delta modulator, updated every clk50m cycle:
- sd <= {1'b0, sd[OUT_W-1:0]} + pcm;
- aud = sd[OUT_W] (the registered carry).
REQ-028 pcm = 0 SHALL give a constant 0 bitstream; pcm = 2^(OUT_W-1) SHALL give a strictly alternating bitstream once settled.

Reset
REQ-029 On reset=1 at a clk50m edge, the block SHALL:
- enter IDLE;
- clear accL, accR, idx, the sd registers, pcm_l and pcm_r;
- drive pcm_valid, overrun, busy, aud_left and aud_right to 0.
REQ-030 Reset mid-pass SHALL abort the pass without a pcm_valid pulse; a ce_sample in the same cycle as reset SHALL be ignored.

Configuration
REQ-031 The macro AUDIO_MIX_SATURATE_EN SHALL select the limiting behaviour:
- defined: a mix above 2^OUT_W-1 clamps to 2^OUT_W-1;
- undefined: the mix is truncated to its low OUT_W bits (wraps).

Verification (NCH=3, IN_W=8, OUT_W=16)
REQ-032 Mono, psg 0x10 on all channels, ear=mic=0, gain=0 -> pcm_l = pcm_r = 16'h0300, with pcm_valid exactly 5 cycles after ce_sample.
REQ-033 ABC, ch0=0xFF, ch1=ch2=0, gain=0 -> pcm_l = 16'h1FE0, pcm_r = 16'h0000; the same stimulus in ACB mode gives the same result.
REQ-034 psg all 0, ear=1, mic=1, gain=0 -> pcm_l = pcm_r = 16'h3000.
REQ-035 ABC, ch0=ch1=0xFF, ear=mic=1, gain=3 -> pcm_l = 16'hFFFF with the macro defined and 16'hFE80 without it.
REQ-036 ce_sample at cycles 0 and 2 -> overrun pulses at cycle 2, a single pcm_valid occurs at cycle 5, and the results match a single-strobe pass.
REQ-037 Sigma-delta and reset checks:
- pcm held at 16'h8000 -> aud_left alternates 0/1 every cycle;
- reset asserted at cycle 3 of a pass -> no pcm_valid, all outputs 0 next cycle.
